wb_deserializer: RTL and testbench
==================================

Name: wb_deserializer

Overview:
- Receive-side companion to the wishbone serializer.
- Samples a single-bit serial line, detects a start bit and shifts in one 27-bit packet of three 9-bit symbols. Each symbol is [k + 8 bits]; k=1 marks a kcode, k=0 marks data.
- Checks the stop bit and holds the packet in a read register.
- Exposes data, status and control to a WISHBONE master, and also presents each packet directly on a side port for hardware consumers.

Parameters:
- ADDR_SIZE, 2, number of ADR_I LSBs decoded.
- FRAME_BITS, 27, payload bits per packet (3 x 9).

Ports:
- CLK_I  in  1  clock.
- RST_I  in  1  synchronous reset, active-high.
- ser_i  in  1  serial line, idles low, synchronous to CLK_I.
- frame_o  out  27  last accepted packet.
- frame_vld_o  out  1  one-cycle pulse when frame_o updates.
- irq_o  out  1  equals the STATUS.valid bit.
- CYC_I  in  1  WB cycle.
- STB_I  in  1  WB strobe.
- WE_I  in  1  WB write enable.
- ADR_I  in  32  WB address; only [ADDR_SIZE-1:0] is decoded.
- DAT_I  in  32  WB write data.
- ACK_O  out  1  WB acknowledge.
- ERR_O  out  1  WB error.
- DAT_O  out  32  WB read data.

Behaviour:
- Reset values: frame_o=0, frame_vld_o=0, irq_o=0, valid=0, overrun=0, frm_err=0, enable=0, FSM=IDLE.
- ACK_O, ERR_O and DAT_O are combinational and are 0 whenever STB_I=0.
- Line frame, one bit per clock:
  - start bit '1';
  - 27 payload bits, MSB first (bit 26 first; symbol [26:18], then [17:9], then [8:0]; k bit leads each symbol);
  - stop bit '0';
  - then idle '0'.
- FSM states:
  - IDLE: if enable=1 and ser_i=1, go to SHIFT with bit counter=0.
  - SHIFT: shift ser_i into the shift register LSB; the counter increments. After the count-26 bit, go to STOP.
  - STOP: if ser_i=0, commit the packet. If ser_i=1, set frm_err and discard the packet. In both cases go to IDLE. A new start bit is accepted only from IDLE, i.e. the cycle after STOP at the earliest.
- Latency: start bit sampled at cycle t, payload at t+1..t+27, stop at t+28. frame_o, frame_vld_o and valid update at the clock edge ending t+28, and are visible from t+29.
- Commit rules:
  - If valid=0: load the holding register and set valid=1.
  - If valid=1 and no DATA read in the same cycle: keep the old data, drop the new packet, set overrun=1. frame_o and frame_vld_o still update.
  - If a commit and a DATA read land in the same cycle: load the new data, valid stays 1, no overrun.
- enable deasserted mid-frame: FSM returns to IDLE on the next edge and the partial packet is discarded; flags are unchanged. RST_I mid-frame returns everything to reset values.
- Register map, on ADR_I[ADDR_SIZE-1:0]:
  - 0 DATA, RO: DAT_O={5'b0, hold[26:0]}. A read (CYC_I & STB_I & !WE_I) clears valid at the next edge. Writes are ignored but still ACKed.
  - 1 STATUS: DAT_O={29'b0, frm_err, overrun, valid}. A write is W1C on bits [2:1]; bit 0 is not writable.
  - 2 CTRL, RW: bit0 = enable; DAT_O={31'b0, enable}.
  - 3: unmapped.
- ACK_O = CYC_I & STB_I for addresses 0-2, zero wait states.
- Unmapped address: ERR_O = CYC_I & STB_I, ACK_O=0, DAT_O=0, no side effects.
- Masters must hold STB_I for exactly one cycle per access. A held STB_I re-triggers side effects every cycle.

Test Plan:
- Reset, then write CTRL=1. Send start, payload 0x6F02434 (symbols {1,BC},{0,12},{0,34}), stop 0 -> frame_vld_o pulses once 29 cycles after the start bit; frame_o=0x6F02434; STATUS reads 0x1; irq_o=1; DATA read returns 0x06F02434; the next STATUS read returns 0x0.
- Send two packets (A=0x0000001, B=0x7FFFFFF) without reading -> DATA=0x0000001 and STATUS=0x3. Write STATUS=0x2 -> STATUS=0x1.
- Send a packet with stop bit=1 -> no frame_vld_o; STATUS=0x4; valid stays 0.
- Schedule a DATA read on the exact commit cycle of a second packet -> DATA then holds the second packet; valid=1; overrun=0.
- Write CTRL=0 at bit 10 of a frame, then re-enable and send a full packet 0x1234567 -> only 0x1234567 is received; no error flags.
- Access address 3 with STB_I -> ERR_O=1, ACK_O=0, DAT_O=0. With ser_i held at 0 and enable=1, the FSM stays in IDLE indefinitely.

Source files
------------

// File: rtl/wb_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : wb_deserializer
// Purpose  : Receives one serial packet (start '1', 27 payload bits MSB first,
//            stop '0') from a single-bit line and holds it in a WISHBONE-readable
//            register. Every accepted packet is also presented on a side port.
// Ports    : CLK_I, RST_I          clock, synchronous active-high reset
//            ser_i                 serial line (idles low)
//            frame_o, frame_vld_o  last accepted packet + one-cycle update pulse
//            irq_o                 mirrors STATUS.valid
//            CYC_I..DAT_O          WISHBONE slave (DATA/STATUS/CTRL registers)
// Revision : 1.0 - initial release
// ============================================================================
module wb_deserializer #(
  parameter int ADDR_SIZE  = 2,
  parameter int FRAME_BITS = 27
) (
  input  logic                  CLK_I,
  input  logic                  RST_I,
  input  logic                  ser_i,
  output logic [FRAME_BITS-1:0] frame_o,
  output logic                  frame_vld_o,
  output logic                  irq_o,
  input  logic                  CYC_I,
  input  logic                  STB_I,
  input  logic                  WE_I,
  input  logic [31:0]           ADR_I,
  input  logic [31:0]           DAT_I,
  output logic                  ACK_O,
  output logic                  ERR_O,
  output logic [31:0]           DAT_O
);

  localparam int CNT_W = $clog2(FRAME_BITS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    STOP  = 2'd2
  } state_t;

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        bit_cnt;
  logic [FRAME_BITS-1:0]   shreg;
  logic [FRAME_BITS-1:0]   hold;
  logic                    valid, overrun, frm_err, enable;
  logic                    commit, stop_err;

  // ---------------------------------------------------------------- bus decode
  logic [ADDR_SIZE-1:0] adr;
  logic                 access, mapped;
  logic                 data_rd, status_wr, ctrl_wr;

  assign adr       = ADR_I[ADDR_SIZE-1:0];
  assign access    = CYC_I & STB_I;
  assign mapped    = (adr < ADDR_SIZE'(3));
  assign data_rd   = access & ~WE_I & (adr == ADDR_SIZE'(0));
  assign status_wr = access &  WE_I & (adr == ADDR_SIZE'(1));
  assign ctrl_wr   = access &  WE_I & (adr == ADDR_SIZE'(2));

  assign ACK_O = access & mapped;
  assign ERR_O = access & ~mapped;
  assign irq_o = valid;

  always_comb begin
    DAT_O = 32'd0;
    if (STB_I) begin
      case (adr)
        ADDR_SIZE'(0): DAT_O = {{(32-FRAME_BITS){1'b0}}, hold};
        ADDR_SIZE'(1): DAT_O = {29'd0, frm_err, overrun, valid};
        ADDR_SIZE'(2): DAT_O = {31'd0, enable};
        default:       DAT_O = 32'd0;
      endcase
    end
  end

  // Address MSBs and unused write-data bits are intentionally ignored.
  logic unused_bits;
  assign unused_bits = ^{ADR_I[31:ADDR_SIZE], DAT_I[31:3]};

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge CLK_I) begin
    if (RST_I) state <= IDLE;
    else       state <= state_nxt;
  end

  // Dropping enable aborts any frame in progress, including one sitting in
  // STOP, so a partially received packet can never be committed.
  always_comb begin
    state_nxt = state;
    commit    = 1'b0;
    stop_err  = 1'b0;
    case (state)
      IDLE: begin
        if (enable && ser_i) state_nxt = SHIFT;
      end
      SHIFT: begin
        if (!enable)                                state_nxt = IDLE;
        else if (bit_cnt == CNT_W'(FRAME_BITS - 1)) state_nxt = STOP;
      end
      STOP: begin
        state_nxt = IDLE;
        if (enable) begin
          commit   = ~ser_i;
          stop_err =  ser_i;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      bit_cnt     <= '0;
      shreg       <= '0;
      hold        <= '0;
      frame_o     <= '0;
      frame_vld_o <= 1'b0;
      valid       <= 1'b0;
      overrun     <= 1'b0;
      frm_err     <= 1'b0;
      enable      <= 1'b0;
    end else begin
      frame_vld_o <= commit;

      if (state == IDLE) begin
        bit_cnt <= '0;
      end else if (state == SHIFT) begin
        shreg   <= {shreg[FRAME_BITS-2:0], ser_i};
        bit_cnt <= bit_cnt + CNT_W'(1);
      end

      if (commit) frame_o <= shreg;

      // A read landing on the commit cycle frees the holding register, so the
      // new packet replaces the old one instead of overrunning it.
      if (commit && (!valid || data_rd)) hold <= shreg;

      if (commit)       valid <= 1'b1;
      else if (data_rd) valid <= 1'b0;

      // Hardware set wins over a simultaneous W1C.
      if (commit && valid && !data_rd)  overrun <= 1'b1;
      else if (status_wr && DAT_I[1])   overrun <= 1'b0;

      if (stop_err)                     frm_err <= 1'b1;
      else if (status_wr && DAT_I[2])   frm_err <= 1'b0;

      if (ctrl_wr) enable <= DAT_I[0];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_deserializer
// Purpose  : Directed self-checking bench for wb_deserializer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_deserializer;

  logic        clk = 1'b0;
  logic        rst;
  logic        ser;
  logic [26:0] frame;
  logic        frame_vld;
  logic        irq;
  logic        cyc, stb, we;
  logic [31:0] adr, dat_w;
  logic        ack, err;
  logic [31:0] dat_r;

  int tests_run = 0;
  int tests_failed = 0;
  int vld_cnt = 0;

  wb_deserializer #(.ADDR_SIZE(2), .FRAME_BITS(27)) dut (
    .CLK_I      (clk),
    .RST_I      (rst),
    .ser_i      (ser),
    .frame_o    (frame),
    .frame_vld_o(frame_vld),
    .irq_o      (irq),
    .CYC_I      (cyc),
    .STB_I      (stb),
    .WE_I       (we),
    .ADR_I      (adr),
    .DAT_I      (dat_w),
    .ACK_O      (ack),
    .ERR_O      (err),
    .DAT_O      (dat_r)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_vld) vld_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = 32'd0; dat_w = 32'd0;
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; dat_w = d;
    tick();
    bus_idle();
  endtask

  task automatic wb_read(input logic [31:0] a, output logic [31:0] d);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a;
    #1;
    d = dat_r;
    tick();
    bus_idle();
  endtask

  // Drives start, payload MSB first and the stop bit, one bit per clock.
  // abort_at: bit index (0 = start) on which CTRL is written to 0.
  // rd_at_stop: issue a DATA read in the stop-bit cycle.
  task automatic send_frame(input logic [26:0] p, input logic stop_b,
                            input int abort_at, input bit rd_at_stop,
                            output logic vld_end, output logic [31:0] rd_data);
    logic [28:0] bits;
    bits    = {1'b1, p, stop_b};
    rd_data = 32'd0;
    for (int i = 0; i < 29; i++) begin
      ser = bits[28-i];
      if (i == abort_at) begin
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'd2; dat_w = 32'd0;
      end
      if (i == 28 && rd_at_stop) begin
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'd0;
        #1;
        rd_data = dat_r;
      end
      tick();
      bus_idle();
    end
    ser     = 1'b0;
    vld_end = frame_vld;
  endtask

  logic [31:0] rd, rd2;
  logic        vend;
  int          vbase;

  initial begin
    rst = 1'b1; ser = 1'b0;
    bus_idle();
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Reset state
    check("rst_frame", {5'd0, frame}, 32'd0);
    check("rst_vld",   {31'd0, frame_vld}, 32'd0);
    check("rst_irq",   {31'd0, irq}, 32'd0);
    check("idle_bus",  {ack, err, dat_r[29:0]}, 32'd0);
    wb_read(32'd1, rd); check("rst_status", rd, 32'd0);
    wb_read(32'd2, rd); check("rst_ctrl",   rd, 32'd0);

    // Enable and basic reception
    wb_write(32'd2, 32'd1);
    wb_read(32'd2, rd); check("ctrl_en", rd, 32'd1);
    vbase = vld_cnt;
    send_frame(27'h6F02434, 1'b0, -1, 1'b0, vend, rd);
    check("vld_at_29", {31'd0, vend}, 32'd1);
    check("vld_early", vld_cnt - vbase, 32'd0);
    check("frame1", {5'd0, frame}, 32'h06F02434);
    check("irq1", {31'd0, irq}, 32'd1);
    tick();
    check("vld_once", vld_cnt - vbase, 32'd1);
    wb_read(32'd1, rd); check("status1", rd, 32'd1);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'd0; #1;
    check("data_ack", {31'd0, ack}, 32'd1);
    check("data1", dat_r, 32'h06F02434);
    tick(); bus_idle();
    wb_read(32'd1, rd); check("status1_clr", rd, 32'd0);
    check("irq1_clr", {31'd0, irq}, 32'd0);

    // Overrun: second packet dropped from the holding register
    send_frame(27'h0000001, 1'b0, -1, 1'b0, vend, rd);
    tick();
    send_frame(27'h7FFFFFF, 1'b0, -1, 1'b0, vend, rd);
    check("ovr_vld", {31'd0, vend}, 32'd1);
    check("ovr_frame", {5'd0, frame}, 32'h07FFFFFF);
    tick();
    wb_read(32'd1, rd); check("ovr_status", rd, 32'd3);
    wb_write(32'd1, 32'd2);
    wb_read(32'd1, rd); check("ovr_w1c", rd, 32'd1);
    wb_read(32'd0, rd); check("ovr_data", rd, 32'h00000001);
    wb_read(32'd1, rd); check("ovr_status0", rd, 32'd0);

    // Framing error
    vbase = vld_cnt;
    send_frame(27'h5555555, 1'b1, -1, 1'b0, vend, rd);
    tick();
    check("ferr_novld", vld_cnt - vbase, 32'd0);
    wb_read(32'd1, rd); check("ferr_status", rd, 32'd4);
    wb_write(32'd1, 32'd4);
    wb_read(32'd1, rd); check("ferr_clr", rd, 32'd0);

    // DATA read coinciding with the commit cycle
    send_frame(27'h0ABCDEF, 1'b0, -1, 1'b0, vend, rd);
    tick();
    send_frame(27'h3C3C3C3, 1'b0, -1, 1'b1, vend, rd2);
    check("coll_rd_old", rd2, 32'h00ABCDEF);
    tick();
    wb_read(32'd1, rd); check("coll_status", rd, 32'd1);
    wb_read(32'd0, rd); check("coll_data", rd, 32'h03C3C3C3);
    wb_read(32'd1, rd); check("coll_status0", rd, 32'd0);

    // Enable dropped mid-frame, then a clean packet
    vbase = vld_cnt;
    send_frame(27'h7FFFFFF, 1'b0, 10, 1'b0, vend, rd);
    repeat (3) tick();
    check("abort_novld", vld_cnt - vbase, 32'd0);
    wb_read(32'd1, rd); check("abort_status", rd, 32'd0);
    wb_write(32'd2, 32'd1);
    send_frame(27'h1234567, 1'b0, -1, 1'b0, vend, rd);
    tick();
    check("reen_vld", vld_cnt - vbase, 32'd1);
    check("reen_frame", {5'd0, frame}, 32'h01234567);
    wb_read(32'd1, rd); check("reen_status", rd, 32'd1);
    wb_read(32'd0, rd); check("reen_data", rd, 32'h01234567);

    // Unmapped address: error, no data, no side effects
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'd3; dat_w = 32'hFFFFFFFF; #1;
    check("unm_err", {31'd0, err}, 32'd1);
    check("unm_ack", {31'd0, ack}, 32'd0);
    check("unm_dat", dat_r, 32'd0);
    tick(); bus_idle();
    wb_read(32'd2, rd); check("unm_ctrl", rd, 32'd1);

    // Line held low: nothing received
    vbase = vld_cnt;
    repeat (60) tick();
    check("idle_novld", vld_cnt - vbase, 32'd0);
    wb_read(32'd1, rd); check("idle_status", rd, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
